// File: rtl/tdc_cnt.sv
// Counter-based time-to-digital converter: measures start-edge to stop-edge
// interval in clk periods and hands the code out over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for arm
// ARMED | waiting for a start edge
// COUNT | counting cycles until a stop edge or saturation
// DONE  | result presented, waiting for ready
module tdc_cnt #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         arm,
  output logic         busy,
  output logic [W-1:0] code,
  output logic         ovf,
  output logic         valid,
  input  logic         ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [W-1:0] CNT_MAX = '1;

  state_t                 state, state_nxt;
  logic [W-1:0]           cnt;
  logic [SYNC_STAGES-1:0] start_sync, stop_sync;
  logic                   start_hist, stop_hist;
  logic                   start_edge, stop_edge;

  // Both paths are identical so their latency cancels in the difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync <= '0;
      stop_sync  <= '0;
      start_hist <= 1'b0;
      stop_hist  <= 1'b0;
    end else begin
      start_sync <= {start_sync[SYNC_STAGES-2:0], start};
      stop_sync  <= {stop_sync[SYNC_STAGES-2:0], stop};
      start_hist <= start_sync[SYNC_STAGES-1];
      stop_hist  <= stop_sync[SYNC_STAGES-1];
    end
  end

  assign start_edge = start_sync[SYNC_STAGES-1] & ~start_hist;
  assign stop_edge  = stop_sync[SYNC_STAGES-1] & ~stop_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arm) state_nxt = ARMED;
      end
      ARMED: begin
        if (start_edge && stop_edge) state_nxt = DONE;
        else if (start_edge)         state_nxt = COUNT;
      end
      COUNT: begin
        if (stop_edge || cnt == CNT_MAX) state_nxt = DONE;
      end
      DONE: begin
        if (ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    valid = (state == DONE);
  end

  // Stop has priority over saturation, so a stop in the last cycle is a real code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      code <= '0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        ARMED: begin
          if (start_edge && stop_edge) begin
            code <= '0;
            ovf  <= 1'b0;
          end else if (start_edge) begin
            cnt <= W'(1);
          end
        end
        COUNT: begin
          if (stop_edge) begin
            code <= cnt;
            ovf  <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            code <= CNT_MAX;
            ovf  <= 1'b1;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
